// File: rtl/gf_pkg.sv
// Shared GF(2^M) definitions: op encoding and elaboration-time table generators.
package gf_pkg;

   typedef enum logic [1:0] {
      OP_MUL = 2'b00,
      OP_DIV = 2'b01,
      OP_INV = 2'b10,
      OP_SQR = 2'b11
   } gf_op_e;

   // Multiply a field element by alpha (x) and reduce by the field polynomial.
   function automatic int unsigned gf_xtime(int unsigned m, int unsigned poly, int unsigned p);
      int unsigned q;
      q = p << 1;
      if (((q >> m) & 1) != 0) q = q ^ poly;
      return q;
   endfunction

   function automatic int unsigned gf_exp(int unsigned m, int unsigned poly, int unsigned i);
      int unsigned p;
      p = 1;
      for (int unsigned k = 0; k < i; k++) p = gf_xtime(m, poly, p);
      return p;
   endfunction

   // log(0) never matches any power and falls back to 0; callers mask it with zero flags.
   function automatic int unsigned gf_log(int unsigned m, int unsigned poly, int unsigned x);
      int unsigned p;
      int unsigned lg;
      logic        found;
      p     = 1;
      lg    = 0;
      found = 1'b0;
      for (int unsigned k = 0; k < (32'd1 << m) - 1; k++) begin
         if (p == x && !found) begin
            lg    = k;
            found = 1'b1;
         end
         p = gf_xtime(m, poly, p);
      end
      return lg;
   endfunction

endpackage

// File: rtl/gf_mul_pipe_if.sv
// Operand/result handshake bundle for gf_mul_pipe.
interface gf_mul_pipe_if #(
   parameter int unsigned M     = 8,
   parameter int unsigned TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [M-1:0]     a;
   logic [M-1:0]     b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [M-1:0]     y;
   logic             err;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, op, a, b, in_tag, out_ready,
      input  in_ready, out_valid, y, err, out_tag
   );

   modport slave (
      input  in_valid, op, a, b, in_tag, out_ready,
      output in_ready, out_valid, y, err, out_tag
   );
endinterface

// File: rtl/gf_log_rom.sv
// Combinational exp/log lookup for GF(2^M); tables are built at elaboration from M and POLY.
module gf_log_rom
   import gf_pkg::*;
#(
   parameter int unsigned M    = 8,
   parameter int unsigned POLY = 'h11D
) (
   input  logic [M-1:0] idx,
   output logic [M-1:0] exp_val,
   output logic [M-1:0] log_val
);
   logic [M-1:0] exp_tab [2**M];
   logic [M-1:0] log_tab [2**M];

   for (genvar i = 0; i < 2**M; i++) begin : g_tab
      assign exp_tab[i] = M'(gf_exp(M, POLY, i));
      assign log_tab[i] = M'(gf_log(M, POLY, i));
   end

   assign exp_val = exp_tab[idx];
   assign log_val = log_tab[idx];
endmodule

// File: rtl/gf_mul_pipe.sv
// GF(2^M) MUL/DIV/INV/SQR via log/antilog tables in three registered stages:
// S1 log lookup, S2 exponent arithmetic and zero/error flags, S3 antilog and output hold.
module gf_mul_pipe
   import gf_pkg::*;
#(
   parameter int unsigned M     = 8,
   parameter int unsigned POLY  = 'h11D,
   parameter int unsigned TAG_W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   gf_mul_pipe_if.slave bus
);
   localparam logic [M:0] N = {1'b0, {M{1'b1}}};

   logic             s1_valid, s2_valid;
   logic             s1_ready, s2_ready, s3_ready;
   gf_op_e           s1_op;
   logic [M-1:0]     s1_la, s1_lb;
   logic             s1_za, s1_zb;
   logic [TAG_W-1:0] s1_tag, s2_tag;
   logic [M-1:0]     s2_e;
   logic             s2_zero, s2_err;
   logic [M-1:0]     la, lb, ey;
   logic [M-1:0]     unused_exp_a, unused_exp_b, unused_log_y;
   logic [M:0]       e, sum, dif, dbl;
   logic             zero_c, err_c;

   // Each stage may load when empty or when its occupant moves on this cycle.
   assign s3_ready     = ~bus.out_valid | bus.out_ready;
   assign s2_ready     = ~s2_valid | s3_ready;
   assign s1_ready     = ~s1_valid | s2_ready;
   assign bus.in_ready = s1_ready;

   gf_log_rom #(.M(M), .POLY(POLY)) u_rom_a (.idx(bus.a), .exp_val(unused_exp_a), .log_val(la));
   gf_log_rom #(.M(M), .POLY(POLY)) u_rom_b (.idx(bus.b), .exp_val(unused_exp_b), .log_val(lb));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        s1_valid <= 1'b0;
      else if (s1_ready) s1_valid <= bus.in_valid;
   end

   always_ff @(posedge clk) begin
      if (s1_ready && bus.in_valid) begin
         s1_op  <= gf_op_e'(bus.op);
         s1_la  <= la;
         s1_lb  <= lb;
         s1_za  <= (bus.a == '0);
         s1_zb  <= (bus.b == '0);
         s1_tag <= bus.in_tag;
      end
   end

   always_comb begin
      sum    = {1'b0, s1_la} + {1'b0, s1_lb};
      dif    = {1'b0, s1_la} - {1'b0, s1_lb};
      dbl    = {s1_la, 1'b0};
      e      = '0;
      zero_c = 1'b0;
      err_c  = 1'b0;
      case (s1_op)
         OP_MUL: begin
            e      = (sum >= N) ? sum - N : sum;
            zero_c = s1_za | s1_zb;
         end
         OP_DIV: begin
            // Wrapped M+1-bit difference plus N lands back in 0..N-1.
            e      = (s1_la < s1_lb) ? dif + N : dif;
            zero_c = s1_za | s1_zb;
            err_c  = s1_zb;
         end
         OP_INV: begin
            e      = (s1_la == '0) ? '0 : N - {1'b0, s1_la};
            zero_c = s1_za;
            err_c  = s1_za;
         end
         default: begin
            e      = (dbl >= N) ? dbl - N : dbl;
            zero_c = s1_za;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        s2_valid <= 1'b0;
      else if (s2_ready) s2_valid <= s1_valid;
   end

   always_ff @(posedge clk) begin
      if (s2_ready && s1_valid) begin
         s2_e    <= e[M-1:0];
         s2_zero <= zero_c;
         s2_err  <= err_c;
         s2_tag  <= s1_tag;
      end
   end

   gf_log_rom #(.M(M), .POLY(POLY)) u_rom_y (.idx(s2_e), .exp_val(ey), .log_val(unused_log_y));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.y         <= '0;
         bus.err       <= 1'b0;
         bus.out_tag   <= '0;
      end else if (s3_ready) begin
         bus.out_valid <= s2_valid;
         if (s2_valid) begin
            bus.y       <= s2_zero ? '0 : ey;
            bus.err     <= s2_err;
            bus.out_tag <= s2_tag;
         end
      end
   end
endmodule

// File: doc/gf_mul_pipe.md
GF_MUL_PIPE -- requirements
Module: gf_mul_pipe

Interface
REQ-001 SHALL have parameter M, default 8: field width in bits, GF(2^M), legal range 3..8.
REQ-002 SHALL have parameter POLY, default 'h11D: primitive polynomial, M+1 bits, bit M set.
REQ-003 SHALL have parameter TAG_W, default 4: width of the user tag carried alongside each operation.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the operand beat is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port op, input, 2 bits: 00 MUL, 01 DIV (a/b), 10 INV (a^-1, b ignored), 11 SQR (a*a, b ignored).
REQ-009 SHALL have ports a and b, input, M bits each: the operands.
REQ-010 SHALL have port in_tag, input, TAG_W bits: user tag.
REQ-011 SHALL have port out_valid, output, 1 bit: the result beat is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port y, output, M bits: the result.
REQ-014 SHALL have port err, output, 1 bit: division by zero or inverse of zero.
REQ-015 SHALL have port out_tag, output, TAG_W bits: the tag of the beat on y.

Function
REQ-016 SHALL accept a beat on a rising edge where in_valid && in_ready; SHALL deliver a result on an edge where out_valid && out_ready.
REQ-017 SHALL be a 3-stage pipeline: S1 log lookup of a and b; S2 exponent arithmetic plus zero/error detection; S3 antilog lookup and output register.
REQ-018 SHALL present out_valid exactly 3 cycles after acceptance when there is no backpressure, and SHALL sustain 1 beat/cycle throughput.
REQ-019 SHALL load each stage register when that stage is empty or its contents advance this cycle; in_ready = ~s1_valid | s1 advancing (a combinational ready chain is permitted).
REQ-020 SHALL hold y, err and out_tag stable while out_valid && !out_ready; no beat is dropped, duplicated or reordered.
REQ-021 SHALL use N = 2^M-1 as the exponent modulus; log values range 0..N-1, and the log of 0 is a don't-care that is masked by the zero flags.
REQ-022 SHALL compute MUL as e = la+lb (M+1-bit sum), subtracting N once when e >= N.
REQ-023 SHALL compute DIV as e = la-lb, adding N when the difference is negative.
REQ-024 SHALL compute INV as e = (la==0) ? 0 : N-la.
REQ-025 SHALL compute SQR as e = 2*la mod N, using a single conditional subtract.
REQ-026 SHALL resolve zero operands as follows: MUL with a==0 or b==0 gives y=0, err=0; DIV with a==0 and b!=0 gives y=0, err=0; DIV with b==0 gives y=0, err=1; INV or SQR with a==0 gives y=0, with err=1 for INV only.
REQ-027 SHALL leave err=0 for all other cases.
REQ-028 SHALL pass in_tag through the pipeline unchanged and aligned with its beat.
REQ-029 SHALL generate the log/antilog tables at elaboration from M and POLY; no hand-written tables.

Reset
REQ-030 SHALL clear all stage valid bits, out_valid, y, err and out_tag to 0 while rst_n is low, regardless of clk.
REQ-031 SHALL discard in-flight beats when reset is asserted mid-operation; in_ready SHALL be 1 in the first cycle after deassertion.
REQ-032 SHALL leave the datapath registers other than the outputs non-reset.

Structure
REQ-033 SHALL place the op encoding constants and the table-generation functions (exp table, log table as functions of M and POLY) in shared package gf_pkg.
REQ-034 SHALL implement the lookups in one sub-module, gf_log_rom (parameters M and POLY; index in, exp and log out), instantiated twice in S1 and once in S3.

Verification (M=8, POLY='h11D)
REQ-035 Bench SHALL check: MUL a=02, b=80 -> y=1D, err=0, out_valid exactly 3 cycles after acceptance.
REQ-036 Bench SHALL check: DIV a=1D, b=02 -> y=80; INV a=02 -> y=8E; SQR a=80 -> y=13; all with err=0.
REQ-037 Bench SHALL check: DIV a=05, b=00 -> y=00, err=1; INV a=00 -> y=00, err=1; MUL a=00, b=37 -> y=00, err=0.
REQ-038 Bench SHALL check: back-to-back beats with tags 0..7 under a random out_ready pattern -> results in order, tags matching, outputs held while stalled, no loss.
REQ-039 Bench SHALL check: rst_n asserted with 3 beats in flight -> out_valid=0 immediately; no stale beat appears after release.
REQ-040 Bench SHALL check: exhaustive MUL over all 65536 operand pairs against a shift-and-reduce reference model, and repeat for M=4, POLY='h13.
